// File: rtl/bno055_sequencer.sv
// BNO055 access sequencer: boot delay, four configuration writes, then periodic
// six-byte Euler bursts with timeout/retry. Optional macro BNO055_CHIPID_CHECK_EN.
module bno055_sequencer #(
  parameter int unsigned BOOT_WAIT_CYCLES = 16_500_000,
  parameter int unsigned MODE_WAIT_CYCLES = 500_000,
  parameter int unsigned POLL_CYCLES      = 250_000,
  parameter int unsigned TIMEOUT_CYCLES   = 100_000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_poll_en,
  output logic [1:0]  o_opcode,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_tx_data,
  input  logic [7:0]  i_reg_data,
  input  logic        i_done,
  output logic [15:0] o_heading,
  output logic [15:0] o_roll,
  output logic [15:0] o_pitch,
  output logic        o_valid,
  output logic        o_ready,
  output logic        o_fault,
  output logic [7:0]  o_err_cnt
);

  // Handshake: o_opcode is nonzero for exactly one cycle (ISSUE state); address and
  // data hold through the WAIT state until i_done or timeout re-issues the transaction.
  typedef enum logic [3:0] {
    S_BOOT_WAIT, S_CHIP_ISSUE, S_CHIP_WAIT, S_CFG_ISSUE, S_CFG_WAIT, S_MODE_WAIT,
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_PUBLISH, S_FAULT
  } state_t;

  localparam logic [31:0] BOOT_LAST = 32'(BOOT_WAIT_CYCLES - 1);
  localparam logic [31:0] MODE_LAST = 32'(MODE_WAIT_CYCLES - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  state_t      state, state_next;
  logic [31:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  retry, retry_next;
  logic [31:0] poll_cnt;
  logic        pending, poll_tick;
  logic        burst_start, capture, drop;
  logic        timed_out, retry_left;
  logic [7:0]  cfg_addr, cfg_data;
  logic [5:0][7:0] rd_bytes;

  assign timed_out  = (cnt == TMO_LAST);
  assign retry_left = (retry < RETRY_LIM);
  assign poll_tick  = (poll_cnt == POLL_LAST);

  always_comb begin
    cfg_addr = 8'h3D;
    cfg_data = 8'h00;
    case (idx)
      3'd1:    cfg_addr = 8'h3E;
      3'd2:    cfg_addr = 8'h3B;
      3'd3:    cfg_data = 8'h0C;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_BOOT_WAIT;
      cnt   <= '0;
      idx   <= '0;
      retry <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      retry <= retry_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    retry_next  = retry;
    burst_start = 1'b0;
    capture     = 1'b0;
    drop        = 1'b0;
    o_opcode    = 2'd0;
    o_reg_addr  = 8'h00;
    o_tx_data   = 8'h00;
    o_ready     = 1'b0;
    o_fault     = 1'b0;
    case (state)
      S_BOOT_WAIT: begin
        cnt_next = cnt + 32'd1;
        if (cnt == BOOT_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          retry_next = '0;
`ifdef BNO055_CHIPID_CHECK_EN
          state_next = S_CHIP_ISSUE;
`else
          state_next = S_CFG_ISSUE;
`endif
        end
      end
`ifdef BNO055_CHIPID_CHECK_EN
      S_CHIP_ISSUE: begin
        o_opcode   = 2'd1;
        cnt_next   = 32'd1;
        state_next = S_CHIP_WAIT;
      end
      S_CHIP_WAIT: begin
        cnt_next = cnt + 32'd1;
        if (i_done) begin
          retry_next = '0;
          state_next = (i_reg_data == 8'hA0) ? S_CFG_ISSUE : S_FAULT;
        end else if (timed_out) begin
          if (retry_left) begin
            retry_next = retry + 8'd1;
            state_next = S_CHIP_ISSUE;
          end else begin
            state_next = S_FAULT;
          end
        end
      end
`endif
      S_CFG_ISSUE: begin
        o_opcode   = 2'd2;
        o_reg_addr = cfg_addr;
        o_tx_data  = cfg_data;
        cnt_next   = 32'd1;
        state_next = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        o_reg_addr = cfg_addr;
        o_tx_data  = cfg_data;
        cnt_next   = cnt + 32'd1;
        if (i_done) begin
          retry_next = '0;
          if (idx == 3'd3) begin
            // The done cycle counts as the first mode-wait cycle.
            cnt_next   = 32'd1;
            state_next = S_MODE_WAIT;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_CFG_ISSUE;
          end
        end else if (timed_out) begin
          if (retry_left) begin
            retry_next = retry + 8'd1;
            state_next = S_CFG_ISSUE;
          end else begin
            state_next = S_FAULT;
          end
        end
      end
      S_MODE_WAIT: begin
        cnt_next = cnt + 32'd1;
        if (cnt == MODE_LAST) state_next = S_IDLE;
      end
      S_IDLE: begin
        o_ready = 1'b1;
        if (pending && i_poll_en) begin
          burst_start = 1'b1;
          idx_next    = '0;
          retry_next  = '0;
          state_next  = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        o_ready    = 1'b1;
        o_opcode   = 2'd1;
        o_reg_addr = 8'h1A + {5'd0, idx};
        cnt_next   = 32'd1;
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        o_ready    = 1'b1;
        o_reg_addr = 8'h1A + {5'd0, idx};
        cnt_next   = cnt + 32'd1;
        if (i_done) begin
          capture    = 1'b1;
          retry_next = '0;
          if (idx == 3'd5) begin
            state_next = S_PUBLISH;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_RD_ISSUE;
          end
        end else if (timed_out) begin
          if (retry_left) begin
            retry_next = retry + 8'd1;
            state_next = S_RD_ISSUE;
          end else begin
            drop       = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_PUBLISH: begin
        o_ready    = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: o_fault = 1'b1;
      default: state_next = S_FAULT;
    endcase
  end

  // Poll timer runs only while ready; one pending tick survives an active burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else if (!o_ready) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      poll_cnt <= poll_tick ? '0 : poll_cnt + 32'd1;
      pending  <= poll_tick | (pending & ~burst_start);
    end
  end

  // Bytes shift in ascending address order, so rd_bytes[0] holds register 0x1A.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_bytes  <= '0;
      o_heading <= '0;
      o_roll    <= '0;
      o_pitch   <= '0;
      o_valid   <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (capture) rd_bytes <= {i_reg_data, rd_bytes[5:1]};
      o_valid <= (state == S_PUBLISH);
      if (state == S_PUBLISH) begin
        o_heading <= {rd_bytes[1], rd_bytes[0]};
        o_roll    <= {rd_bytes[3], rd_bytes[2]};
        o_pitch   <= {rd_bytes[5], rd_bytes[4]};
      end
      if (drop && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule
